// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer: phase bit positions, opcode bytes, state encoding.
package fetch_sequencer_pkg;

    localparam int unsigned PHASE_W = 5;
    localparam int unsigned PH_F    = 0;
    localparam int unsigned PH_R    = 1;
    localparam int unsigned PH_X    = 2;
    localparam int unsigned PH_M    = 3;
    localparam int unsigned PH_W    = 4;

    localparam int unsigned OPC_W   = 8;

    localparam logic [OPC_W-1:0] OP_ZADD  = 8'h01;
    localparam logic [OPC_W-1:0] OP_ZSUB  = 8'h29;
    localparam logic [OPC_W-1:0] OP_ZCMP  = 8'h39;
    localparam logic [OPC_W-1:0] OP_ZAND  = 8'h21;
    localparam logic [OPC_W-1:0] OP_ZOR   = 8'h09;
    localparam logic [OPC_W-1:0] OP_ZXOR  = 8'h31;
    localparam logic [OPC_W-1:0] OP_ZLD   = 8'h8B;
    localparam logic [OPC_W-1:0] OP_ZST   = 8'h89;
    localparam logic [OPC_W-1:0] OP_ZLIL  = 8'h66;
    localparam logic [OPC_W-1:0] OP_IMM   = 8'h83;
    localparam logic [OPC_W-1:0] OP_UNARY = 8'hF7;
    localparam logic [OPC_W-1:0] OP_SHIFT = 8'hC1;
    localparam logic [OPC_W-1:0] OP_JMP   = 8'h90;
    localparam logic [OPC_W-1:0] OP_HLT   = 8'hF4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_F    = 3'd1,
        S_R    = 3'd2,
        S_X    = 3'd3,
        S_M    = 3'd4,
        S_W    = 3'd5,
        S_HALT = 3'd6
    } state_t;

    // One-hot phase vector with only bit idx set.
    function automatic logic [PHASE_W-1:0] ph_bit(input int unsigned idx);
        return PHASE_W'(1) << idx;
    endfunction

endpackage

// File: rtl/fetch_sequencer_ilen_decode.sv
// Opcode byte to instruction length / legality / halt classification.
module ilen_decode
    import fetch_sequencer_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic [1:0]       len,
    output logic             legal,
    output logic             is_hlt
);

    // Pure lookup; unknown opcodes report len 0 and legal 0.
    always_comb begin
        len    = 2'd0;
        legal  = 1'b0;
        is_hlt = 1'b0;
        case (opcode)
            OP_HLT: begin
                len    = 2'd1;
                legal  = 1'b1;
                is_hlt = 1'b1;
            end
            OP_ZLIL, OP_IMM, OP_SHIFT, OP_JMP: begin
                len   = 2'd3;
                legal = 1'b1;
            end
            OP_ZADD, OP_ZSUB, OP_ZCMP, OP_ZAND, OP_ZOR,
            OP_ZXOR, OP_ZLD, OP_ZST, OP_UNARY: begin
                len   = 2'd2;
                legal = 1'b1;
            end
            default: begin
                len    = 2'd0;
                legal  = 1'b0;
                is_hlt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch and phase sequencer: fetches into ir, steps f-r-x-m-w, maintains pc.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        ir,
    output logic [PHASE_W-1:0] phase,
    output logic [31:0]        pc,
    input  logic               cr_taken,
    input  logic [31:0]        br_target,
    output logic               halted,
    output logic               illegal,
    output logic               fault
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       len;
    logic             legal;
    logic             is_hlt;

    // Classify the opcode currently held in ir.
    ilen_decode u_ilen_decode (
        .opcode (ir[31:24]),
        .len    (len),
        .legal  (legal),
        .is_hlt (is_hlt)
    );

    // The fetch address is always the pc register itself.
    assign imem_addr = pc;

    // Sequencer: state, pc, ir and all status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            ir       <= 32'h0;
            phase    <= '0;
            imem_req <= 1'b0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
            fault    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_F;
                        imem_req <= 1'b1;
                        phase    <= ph_bit(PH_F);
                        wait_cnt <= '0;
                    end
                end
                S_F: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        state    <= S_R;
                        imem_req <= 1'b0;
                        phase    <= ph_bit(PH_R);
                    end else if (wait_cnt == CNT_LAST) begin
                        fault    <= 1'b1;
                        state    <= S_HALT;
                        imem_req <= 1'b0;
                        phase    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_R: begin
                    // Unknown opcodes stop here, before pc moves.
                    if (!legal) begin
                        illegal <= 1'b1;
                        state   <= S_HALT;
                        phase   <= '0;
                    end else begin
                        state <= S_X;
                        phase <= ph_bit(PH_X);
                    end
                end
                S_X: begin
                    state <= S_M;
                    phase <= ph_bit(PH_M);
                end
                S_M: begin
                    state <= S_W;
                    phase <= ph_bit(PH_W);
                end
                S_W: begin
                    if (cr_taken) begin
                        pc <= br_target;
                    end else begin
                        pc <= pc + 32'(len);
                    end
                    // HLT still advances pc, then parks.
                    if (is_hlt) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                        phase  <= '0;
                    end else begin
                        state    <= S_F;
                        imem_req <= 1'b1;
                        phase    <= ph_bit(PH_F);
                        wait_cnt <= '0;
                    end
                end
                S_HALT: begin
                    imem_req <= 1'b0;
                    phase    <= '0;
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                    phase    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [4:0]  phase;
    logic [31:0] pc;
    logic        cr_taken;
    logic [31:0] br_target;
    logic        halted;
    logic        illegal;
    logic        fault;

    int errors = 0;
    int checks = 0;

    fetch_sequencer #(
        .RESET_PC    (32'h0000_0100),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .phase      (phase),
        .pc         (pc),
        .cr_taken   (cr_taken),
        .br_target  (br_target),
        .halted     (halted),
        .illegal    (illegal),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one instruction starting in F; ends one cycle after W.
    task automatic do_instr(input logic [31:0] rdata, input int wait_cycles,
                            input logic taken, input logic [31:0] target,
                            input logic [31:0] exp_next, input logic exp_halt);
        for (int i = 0; i < wait_cycles; i++) begin
            check("wait_req", 32'(imem_req), 32'h1);
            tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check("ir_latch", ir, rdata);
        check("phase_r", 32'(phase), 32'h02);
        check("req_drop", 32'(imem_req), 32'h0);
        tick();
        check("phase_x", 32'(phase), 32'h04);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check("phase_m", 32'(phase), 32'h08);
        check("ack_ignored", ir, rdata);
        tick();
        check("phase_w", 32'(phase), 32'h10);
        cr_taken  = taken;
        br_target = target;
        tick();
        cr_taken  = 1'b0;
        br_target = 32'h0;
        check("pc_next", pc, exp_next);
        if (exp_halt) begin
            check("halted", 32'(halted), 32'h1);
            check("halt_phase", 32'(phase), 32'h0);
            check("halt_req", 32'(imem_req), 32'h0);
        end else begin
            check("phase_f", 32'(phase), 32'h01);
            check("next_req", 32'(imem_req), 32'h1);
            check("next_addr", imem_addr, exp_next);
        end
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        cr_taken   = 1'b0;
        br_target  = 32'h0;

        // Asynchronous reset values.
        #2 rst = 1'b1;
        #1;
        check("rst_pc", pc, 32'h100);
        check("rst_ir", ir, 32'h0);
        check("rst_phase", 32'(phase), 32'h0);
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_flags", {29'h0, halted, illegal, fault}, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_req", 32'(imem_req), 32'h0);

        // Start, then reset mid-fetch drops req without a clock.
        start = 1'b1;
        tick();
        check("f_req", 32'(imem_req), 32'h1);
        check("f_addr", imem_addr, 32'h100);
        check("f_phase", 32'(phase), 32'h01);
        rst = 1'b1;
        #1;
        check("midf_rst_req", 32'(imem_req), 32'h0);
        check("midf_rst_phase", 32'(phase), 32'h0);
        check("midf_rst_pc", pc, 32'h100);
        rst = 1'b0;
        tick();
        start = 1'b0;
        check("restart_req", 32'(imem_req), 32'h1);
        check("restart_addr", imem_addr, 32'h100);

        // Instruction stream, start released mid-run.
        do_instr(32'h01C3_0000, 2, 1'b0, 32'h0,         32'h0000_0102, 1'b0);
        do_instr(32'h90E0_0500, 1, 1'b1, 32'h208,       32'h0000_0208, 1'b0);
        do_instr(32'h90E0_0500, 0, 1'b0, 32'h0,         32'h0000_020B, 1'b0);
        do_instr(32'h90E0_0500, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_instr(32'h2900_0000, 0, 1'b0, 32'h0,         32'h0000_0001, 1'b0);
        do_instr(32'hC100_0000, 1, 1'b0, 32'h0,         32'h0000_0004, 1'b0);
        do_instr(32'hF700_0000, 0, 1'b0, 32'h0,         32'h0000_0006, 1'b0);
        do_instr(32'hF400_0000, 0, 1'b0, 32'h0,         32'h0000_0007, 1'b1);

        // HALT is sticky and ignores start.
        start = 1'b1;
        repeat (4) tick();
        check("hlt_sticky_req", 32'(imem_req), 32'h0);
        check("hlt_sticky_flag", 32'(halted), 32'h1);
        check("hlt_sticky_pc", pc, 32'h7);
        start = 1'b0;

        // Illegal opcode halts from R without moving pc.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        check("rst_clears_halt", 32'(halted), 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ill_addr", imem_addr, 32'h100);
        imem_ack   = 1'b1;
        imem_rdata = 32'hAA00_0000;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check("ill_phase_r", 32'(phase), 32'h02);
        check("ill_not_yet", 32'(illegal), 32'h0);
        tick();
        check("ill_flag", 32'(illegal), 32'h1);
        check("ill_phase", 32'(phase), 32'h0);
        check("ill_pc", pc, 32'h100);
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        check("ill_sticky_req", 32'(imem_req), 32'h0);

        // Ack never arrives: fault after 16 cycles in F.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        check("rst_clears_ill", 32'(illegal), 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        check("to_not_yet", 32'(fault), 32'h0);
        check("to_still_req", 32'(imem_req), 32'h1);
        tick();
        check("to_fault", 32'(fault), 32'h1);
        check("to_req", 32'(imem_req), 32'h0);
        check("to_phase", 32'(phase), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the CPU decoder: fetches each instruction word from instruction memory, holds it in `ir`, and steps the one-hot phase f→r→x→m→w.
- Maintains the PC: advances by the opcode-derived instruction length, or takes the branch target when the decoder reports `cr_taken`.
- Stops on HLT or an unrecognised opcode. Sits between instruction memory and decoder/ALU/regfile.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ACK_TIMEOUT, 16, cycles `imem_req` may wait for `imem_ack` before `fault` is raised.

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  level; leaves IDLE and begins fetching at pc
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  32  byte address of the fetch, equals pc
- imem_ack  in  1  one-cycle strobe; imem_rdata valid in that cycle
- imem_rdata  in  32  instruction bytes, opcode in [31:24], left-aligned
- ir  out  32  latched instruction to decoder
- phase  out  5  one-hot, bit0=f, 1=r, 2=x, 3=m, 4=w; 0 when IDLE/HALT
- pc  out  32  address of instruction in ir
- cr_taken  in  1  from decoder, sampled only in w
- br_target  in  32  ALU result (pc+disp+3), sampled only in w
- halted  out  1  HLT retired
- illegal  out  1  unknown opcode fetched
- fault  out  1  fetch timeout

Behaviour:
- Reset (async): state=IDLE, pc=RESET_PC, ir=0, phase=0, imem_req=0, halted=illegal=fault=0, timeout counter=0.
- States: IDLE, F, R, X, M, W, HALT. phase = one-hot of F..W.
- IDLE:
  - start=1 → F. imem_req rises the next cycle; no combinational path from start.
- F:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: ir<=imem_rdata, go to R.
  - While ack=0, stay in F and increment the timeout counter.
  - Counter reaching ACK_TIMEOUT → fault=1, HALT.
- R→X→M→W: unconditional, one cycle each.
- Minimum instruction latency: 5 cycles + ack wait.
- Opcode check in R (ilen_decode on ir[31:24]):
  - Unrecognised opcode → illegal=1, HALT from R; pc is not updated.
- Length rule from ir[31:24]:
  - F4 → 1 byte.
  - 83, C1, 66, 90 → 3 bytes.
  - 01, 29, 39, 21, 09, 31, 8B, 89, F7 → 2 bytes.
- In W:
  - cr_taken=1 → pc<=br_target; else pc<=pc+len (32-bit, wraps mod 2^32).
  - Then → F, or → HALT with halted=1 if ir[31:24]=F4 (pc still advanced by 1).
- HALT:
  - Sticky until rst; imem_req=0, phase=0.
  - start is ignored.
- Boundaries:
  - ack in the same cycle req first rises is legal (zero-wait).
  - ack outside F is ignored.
  - cr_taken outside W is ignored.
  - rst mid-fetch drops imem_req immediately.
  - pc=FFFF_FFFF + 2 wraps to 0000_0001.
  - start deasserted mid-instruction does not stop execution.

Decomposition:
- Shared package:
  - phase bit indices f=0, r=1, x=2, m=3, w=4.
  - Opcode byte constants (zADD 01, zSUB 29, zCMP 39, zAND 21, zOR 09, zXOR 31, zLD 8B, zST 89, zLIL 66, IMM 83, UNARY F7, SHIFT C1, JMP 90, HLT F4).
  - State encoding.
- One sub-module, ilen_decode: combinational, opcode byte → {len[1:0], legal, is_hlt}. Shared later by the disassembler bench.

Test Plan:
- Reset: rst pulse mid-F with RESET_PC=0x100 → all outputs 0, pc=0x100, imem_req=0 asynchronously; start → imem_addr=0x100.
- Reg-reg fetch: rdata=0x01C3_0000 (zADD), ack 2 cycles after req → ir=0x01C30000, phase 01→02→04→08→10, next imem_addr=pc+2.
- Taken branch: rdata=0x90E0_0500, cr_taken=1, br_target=0x208 in W → next fetch at 0x208. Repeat with cr_taken=0 → pc+3.
- HLT: rdata=0xF400_0000 → halted=1 after W, pc advanced by 1, phase=0, no further imem_req despite start=1.
- Illegal and timeout:
  - Opcode 0xAA → illegal=1 after R, pc unchanged.
  - ack never asserted → fault=1 after 16 cycles in F.
- Wrap: pc=0xFFFF_FFFF, 2-byte opcode 0x29 → next imem_addr=0x0000_0001.
